// File: rtl/tpu_seq_core.sv
// Sequencing/data-staging core of the 2x2 TPU: run FSM, activation skew, column accumulators.
// Optional build macro ACC_RELU_EN: captured values with MSB set are stored as zero.
module tpu_seq_core #(
   parameter int unsigned ADDR_W    = 13,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned ACC_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] a11,
   input  logic [DATA_W-1:0] a12,
   input  logic [DATA_W-1:0] a21,
   input  logic [DATA_W-1:0] a22,
   input  logic [DATA_W-1:0] acc_in1,
   input  logic [DATA_W-1:0] acc_in2,
   output logic              load_weight,
   output logic              load_input,
   output logic              valid,
   output logic              store,
   output logic [ADDR_W-1:0] base_address,
   output logic [DATA_W-1:0] a_in1,
   output logic [DATA_W-1:0] a_in2,
   output logic [DATA_W-1:0] acc1_mem_0,
   output logic [DATA_W-1:0] acc1_mem_1,
   output logic [DATA_W-1:0] acc2_mem_0,
   output logic [DATA_W-1:0] acc2_mem_1,
   output logic              acc1_full,
   output logic              acc2_full,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_IN, S_COMPUTE, S_STORE, S_DONE
   } state_t;

   localparam int unsigned   KW     = $clog2(ACC_LAT + 3);
   localparam logic [KW-1:0] K_ACC1 = KW'(ACC_LAT);
   localparam logic [KW-1:0] K_ACC2 = KW'(ACC_LAT + 1);
   localparam logic [KW-1:0] K_LAST = KW'(ACC_LAT + 2);

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [DATA_W-1:0] acc1_m0_q, acc1_m0_d, acc1_m1_q, acc1_m1_d;
   logic [DATA_W-1:0] acc2_m0_q, acc2_m0_d, acc2_m1_q, acc2_m1_d;
   logic              acc1_full_q, acc1_full_d, acc2_full_q, acc2_full_d;

   function automatic logic [DATA_W-1:0] capture(input logic [DATA_W-1:0] d);
`ifdef ACC_RELU_EN
      return d[DATA_W-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         acc1_m0_q   <= '0;
         acc1_m1_q   <= '0;
         acc2_m0_q   <= '0;
         acc2_m1_q   <= '0;
         acc1_full_q <= 1'b0;
         acc2_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         acc1_m0_q   <= acc1_m0_d;
         acc1_m1_q   <= acc1_m1_d;
         acc2_m0_q   <= acc2_m0_d;
         acc2_m1_q   <= acc2_m1_d;
         acc1_full_q <= acc1_full_d;
         acc2_full_q <= acc2_full_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_LOAD_W;
         S_LOAD_W:  state_d = S_LOAD_IN;
         S_LOAD_IN: state_d = S_COMPUTE;
         S_COMPUTE: if (k_q == K_LAST) state_d = S_STORE;
         S_STORE:   state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      k_d = (state_q == S_COMPUTE && k_q != K_LAST) ? k_q + KW'(1) : '0;
   end

   // Clearing happens on the edge that enters LOAD_W, so LOAD_W already shows empty accumulators.
   always_comb begin
      acc1_m0_d   = acc1_m0_q;
      acc1_m1_d   = acc1_m1_q;
      acc2_m0_d   = acc2_m0_q;
      acc2_m1_d   = acc2_m1_q;
      acc1_full_d = acc1_full_q;
      acc2_full_d = acc2_full_q;
      if (state_q == S_IDLE && start) begin
         acc1_m0_d   = '0;
         acc1_m1_d   = '0;
         acc2_m0_d   = '0;
         acc2_m1_d   = '0;
         acc1_full_d = 1'b0;
         acc2_full_d = 1'b0;
      end else if (state_q == S_COMPUTE) begin
         if (k_q == K_ACC1) acc1_m0_d = capture(acc_in1);
         if (k_q == K_ACC2) begin
            acc1_m1_d   = capture(acc_in1);
            acc1_full_d = 1'b1;
            acc2_m0_d   = capture(acc_in2);
         end
         if (k_q == K_LAST) begin
            acc2_m1_d   = capture(acc_in2);
            acc2_full_d = 1'b1;
         end
      end
   end

   always_comb begin
      load_weight  = (state_q == S_LOAD_W);
      load_input   = (state_q == S_LOAD_IN);
      valid        = (state_q == S_COMPUTE);
      store        = (state_q == S_STORE);
      done         = (state_q == S_DONE);
      base_address = (state_q == S_IDLE) ? '0 : ADDR_W'(BASE_ADDR);
      a_in1        = '0;
      a_in2        = '0;
      if (state_q == S_COMPUTE) begin
         if (k_q == KW'(0)) begin
            a_in1 = a11;
         end else if (k_q == KW'(1)) begin
            a_in1 = a21;
            a_in2 = a12;
         end else if (k_q == KW'(2)) begin
            a_in2 = a22;
         end
      end
   end

   assign acc1_mem_0 = acc1_m0_q;
   assign acc1_mem_1 = acc1_m1_q;
   assign acc2_mem_0 = acc2_m0_q;
   assign acc2_mem_1 = acc2_m1_q;
   assign acc1_full  = acc1_full_q;
   assign acc2_full  = acc2_full_q;

endmodule

// File: tb/tb_tpu_seq_core.sv
// Scoreboarded bench for tpu_seq_core: per-cycle expected outputs queued by stimulus, checked by a monitor.
module tb_tpu_seq_core;

   localparam int unsigned   ADDR_W = 13;
   localparam int unsigned   DATA_W = 8;
   localparam logic [12:0]   BASE   = 13'h123;
`ifdef ACC_RELU_EN
   localparam logic [7:0]    RF0    = 8'h00;
`else
   localparam logic [7:0]    RF0    = 8'hF0;
`endif

   logic clk = 1'b0;
   logic reset, start;
   logic [7:0] a11, a12, a21, a22, acc_in1, acc_in2;
   logic load_weight, load_input, valid, store, done, acc1_full, acc2_full;
   logic [12:0] base_address;
   logic [7:0] a_in1, a_in2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;

   typedef struct {
      int unsigned cyc;
      logic [4:0]  ctl;
      logic [12:0] ba;
      logic [7:0]  ai1, ai2, m10, m11, m20, m21;
      logic [1:0]  ff;
   } exp_t;

   exp_t exp_q[$];
   int unsigned checks = 0, failures = 0, cycn = 0;

   always #5 clk = ~clk;

   tpu_seq_core #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(32'h123), .ACC_LAT(2)) dut (
      .clk(clk), .reset(reset), .start(start),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .acc_in1(acc_in1), .acc_in2(acc_in2),
      .load_weight(load_weight), .load_input(load_input), .valid(valid), .store(store),
      .base_address(base_address), .a_in1(a_in1), .a_in2(a_in2),
      .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
      .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
      .acc1_full(acc1_full), .acc2_full(acc2_full), .done(done)
   );

   task automatic chk(input string nm, input int unsigned c, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, req);
      end
   endtask

   // ctl = {load_weight, load_input, valid, store, done}; ff = {acc1_full, acc2_full}
   task automatic cyc(input logic st, input logic rs, input logic [7:0] i1, input logic [7:0] i2,
                      input logic [4:0] ctl, input logic [7:0] ai1, input logic [7:0] ai2,
                      input logic [7:0] m10, input logic [7:0] m11, input logic [7:0] m20,
                      input logic [7:0] m21, input logic [1:0] ff);
      exp_t e;
      @(posedge clk);
      #1;
      start = st; reset = rs; acc_in1 = i1; acc_in2 = i2;
      e.cyc = cycn; e.ctl = ctl; e.ba = (ctl != 5'b0) ? BASE : 13'h0;
      e.ai1 = ai1; e.ai2 = ai2; e.m10 = m10; e.m11 = m11; e.m20 = m20; e.m21 = m21; e.ff = ff;
      exp_q.push_back(e);
      cycn++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("ctl", e.cyc, 16'({load_weight, load_input, valid, store, done}), 16'(e.ctl));
         chk("base_address", e.cyc, 16'(base_address), 16'(e.ba));
         chk("a_in1", e.cyc, 16'(a_in1), 16'(e.ai1));
         chk("a_in2", e.cyc, 16'(a_in2), 16'(e.ai2));
         chk("acc1_mem_0", e.cyc, 16'(acc1_mem_0), 16'(e.m10));
         chk("acc1_mem_1", e.cyc, 16'(acc1_mem_1), 16'(e.m11));
         chk("acc2_mem_0", e.cyc, 16'(acc2_mem_0), 16'(e.m20));
         chk("acc2_mem_1", e.cyc, 16'(acc2_mem_1), 16'(e.m21));
         chk("full", e.cyc, 16'({acc1_full, acc2_full}), 16'(e.ff));
      end
   end

   initial begin
      reset = 1'b1; start = 1'b0;
      a11 = 8'd1; a12 = 8'd2; a21 = 8'd3; a22 = 8'd4;
      acc_in1 = 8'hAA; acc_in2 = 8'hAA;
      // reset for two cycles
      cyc(0, 1, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      // run 1
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b10000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b01000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 1, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 3, 2, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'd5,  8'h99, 5'b00100, 0, 4, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'd7,  8'd6,  5'b00100, 0, 0, 5, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'h66, 8'd8,  5'b00100, 0, 0, 5, 7, 6, 0, 2'b10);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00010, 0, 0, 5, 7, 6, 8, 2'b11);
      // start held from DONE into IDLE launches run 2
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00001, 0, 0, 5, 7, 6, 8, 2'b11);
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 5, 7, 6, 8, 2'b11);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b10000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b01000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 1, 0, 0, 0, 0, 0, 2'b00);
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00100, 3, 2, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hF0, 8'h5A, 5'b00100, 0, 4, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'h22, 8'h33, 5'b00100, 0, 0, RF0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'h77, 8'h44, 5'b00100, 0, 0, RF0, 8'h22, 8'h33, 0, 2'b10);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00010, 0, 0, RF0, 8'h22, 8'h33, 8'h44, 2'b11);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00001, 0, 0, RF0, 8'h22, 8'h33, 8'h44, 2'b11);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, RF0, 8'h22, 8'h33, 8'h44, 2'b11);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, RF0, 8'h22, 8'h33, 8'h44, 2'b11);
      // run 3: reset at k=1
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, RF0, 8'h22, 8'h33, 8'h44, 2'b11);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b10000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b01000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 1, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 1, 8'hAA, 8'hAA, 5'b00100, 3, 2, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      // run 4: reset at k=4 with captured data present
      cyc(1, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b10000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b01000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 1, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00100, 3, 2, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'd5,  8'hAA, 5'b00100, 0, 4, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'd7,  8'd6,  5'b00100, 0, 0, 5, 0, 0, 0, 2'b00);
      cyc(0, 1, 8'hAA, 8'd8,  5'b00100, 0, 0, 5, 7, 6, 0, 2'b10);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      cyc(0, 0, 8'hAA, 8'hAA, 5'b00000, 0, 0, 0, 0, 0, 0, 2'b00);
      // drain scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
